clk_div_n: RTL and testbench
============================

# clk_div_n

Parametrised integer clock divider: generates a divided clock `clk_out` of any runtime-programmable divisor N ≥ 2 from `clk`. It adds glitch-free start/stop, a divisor update applied only at period boundaries, optional exact 50 % duty for odd N, and built-in verification counters. It is the general-purpose successor to the fixed divide-by-5 block and sits at the root of any derived-clock or clock-enable tree in the design.

## Interface
- `CNT_W`, 8: width of divisor and period counter; max N = 2^CNT_W−1.
- `DIV_DEFAULT`, 5: divisor after reset; must be ≥ 2.
- `ODD_50`, 0: 1 = exact 50 % duty for odd N (adds one negedge flop); 0 = posedge-only.
- `STAT_W`, 32: width of verification counters.
- `clk` in 1: single clock, all state on posedge (plus negedge duty flop when `ODD_50`=1).
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: run request.
- `div_i` in CNT_W: new divisor value.
- `div_load` in 1: one-cycle strobe, captures `div_i`.
- `clk_out` out 1: divided clock, registered.
- `tick` out 1: one-cycle pulse aligned with each `clk_out` period start.
- `div_cur` out CNT_W: divisor currently in effect.
- `div_ack` out 1: one-cycle pulse, a loaded divisor took effect.
- `div_err` out 1: one-cycle pulse, rejected load (`div_i` < 2).
- `clk_cnt` out STAT_W: `clk` posedges since reset.
- `out_cnt` out STAT_W: `clk_out` periods started since reset.

## Operation
- FSM states: IDLE, RUN.
- IDLE: `clk_out`=0, `tick`=0, `cnt`=0. When `en`=1 at an edge: go to RUN, `cnt`<=0, `clk_out`<=1, `tick`<=1.
- RUN: `cnt` counts 0..N−1. `clk_out` is high for `cnt` in [0, H−1], where H = ceil(N/2); low otherwise. Even N: N/2 high, N/2 low. Odd N with `ODD_50`=0: (N+1)/2 high, (N−1)/2 low.
- Wrap (`cnt`=N−1):
  - If `en`=0: go to IDLE with `clk_out`<=0. A period is never truncated, so no runt pulses.
  - Otherwise: `cnt`<=0, `tick`<=1, and any pending divisor is applied.
- Divisor load:
  - `div_i` < 2: pulse `div_err`, ignore the load, leave `div_cur` and any pending value unchanged.
  - In IDLE: `div_cur`<=`div_i`, `div_ack` pulses the next cycle.
  - In RUN: the value is stored as pending. It is applied at the next wrap, with `div_ack` coincident with that `tick`.
  - Repeated loads before the wrap: latest wins, and only one `div_ack` is issued.
  - Load on the same edge as the wrap: applied at that wrap.
- `ODD_50`=1, odd N: a negedge flop `neg_q` samples the posedge output; `clk_out` = `pos_q` & `neg_q`. This gives exactly N/2 cycles high, with the rising edge delayed ½ `clk`. For even N, `clk_out` = `pos_q`.
- Counters: `clk_cnt` increments every posedge. `out_cnt` increments on every `tick`. Both wrap modulo 2^STAT_W.

## Timing
- Reset values: IDLE, `cnt`=0, `clk_out`=0, `tick`=0, `div_cur`=DIV_DEFAULT, pending cleared, `div_ack`=0, `div_err`=0, `clk_cnt`=0, `out_cnt`=0. Asserting `rst` mid-run forces all of these immediately (async), including `neg_q`=0.
- Start latency: `en` sampled high at edge k gives `clk_out` and `tick` high after edge k.
- Period is exactly N `clk` cycles. `tick` is high during the first cycle of each period.
- Stop latency: at most N cycles after `en` falls, ending at the wrap.
- `div_err` and IDLE-state `div_ack`: one cycle after the `div_load` edge.
- `en` toggling within a period has no effect until the wrap.

## Structure
- Package `clk_div_pkg`: FSM state enum (IDLE, RUN), `DIV_MIN`=2, function `hi_len(N)` = ceil(N/2).
- Sub-module `clk_div_stat`: the two STAT_W verification counters, fed by `tick`.
- The divider FSM, counter and duty logic stay in `clk_div_n`.

## Test plan
- Reset, `en`=1, N=5, `ODD_50`=0 → `clk_out` pattern 1,1,1,0,0 repeating; `tick` every 5 cycles; after 50 cycles `out_cnt`=10, `clk_cnt`=50.
- `div_load` with `div_i`=4 in IDLE, then run → 2 high/2 low; `div_ack` pulses once; `div_cur`=4.
- N=5 running, load 8 at `cnt`=2 then 6 at `cnt`=3 → current 5-cycle period completes; next period is 6 cycles (3/3); one `div_ack` with that `tick`.
- `div_load` with `div_i`=1 → `div_err` pulse; `div_cur` stays 5; output unchanged.
- `en` dropped at `cnt`=1 (N=5) → period finishes, `clk_out` low in IDLE; `en` re-raised → restart at `cnt`=0 with `tick`; `rst` pulsed mid-period → all outputs zero immediately.
- `ODD_50`=1, N=5, 10 ns `clk` → `clk_out` high 25 ns, low 25 ns; period 50 ns.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable integer clock divider.
package clk_div_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Smallest divisor that still yields a real high and low phase.
  localparam int DIV_MIN = 2;

  // Number of clk cycles clk_out stays high in one period: ceil(n/2).
  function automatic logic [31:0] hi_len(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_stat.sv
// Free-running observation counters: input clock edges and output periods.
module clk_div_stat #(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  output logic [STAT_W-1:0] clk_cnt,
  output logic [STAT_W-1:0] out_cnt
);

  logic [STAT_W-1:0] clk_cnt_r;
  logic [STAT_W-1:0] out_cnt_r;

  // Count every clk posedge; wraps naturally at 2^STAT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt_r <= {STAT_W{1'b0}};
    end else begin
      clk_cnt_r <= clk_cnt_r + STAT_W'(1);
    end
  end

  // Count one per tick, i.e. one per clk_out period started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt_r <= {STAT_W{1'b0}};
    end else if (tick) begin
      out_cnt_r <= out_cnt_r + STAT_W'(1);
    end else begin
      out_cnt_r <= out_cnt_r;
    end
  end

  assign clk_cnt = clk_cnt_r;
  assign out_cnt = out_cnt_r;

endmodule

// File: rtl/clk_div_n.sv
// Runtime-programmable integer clock divider with glitch-free start/stop,
// period-boundary divisor updates and optional 50 % duty for odd divisors.
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 5,
  parameter int ODD_50      = 0,
  parameter int STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_i,
  input  logic              div_load,
  output logic              clk_out,
  output logic              tick,
  output logic [CNT_W-1:0]  div_cur,
  output logic              div_ack,
  output logic              div_err,
  output logic [STAT_W-1:0] clk_cnt,
  output logic [STAT_W-1:0] out_cnt
);

  localparam logic [CNT_W-1:0] DIV_MIN_W = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] DIV_RST_W = CNT_W'(DIV_DEFAULT);

  state_e           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [CNT_W-1:0] div_cur_r, div_cur_nxt_s;
  logic [CNT_W-1:0] pend_r, pend_nxt_s;
  logic             pend_vld_r, pend_vld_nxt_s;
  logic             pos_q_r, pos_q_nxt_s;
  logic             tick_r, tick_nxt_s;
  logic             ack_r, ack_nxt_s;
  logic             err_r, err_nxt_s;
  logic             neg_q_r;
  logic             load_ok_s, load_bad_s, wrap_s, odd_mode_s;

  assign load_ok_s  = div_load && (div_i >= DIV_MIN_W);
  assign load_bad_s = div_load && (div_i <  DIV_MIN_W);
  assign wrap_s     = (cnt_r == (div_cur_r - CNT_W'(1)));
  assign cnt_inc_s  = cnt_r + CNT_W'(1);

  // Next-state, counter, duty and divisor-update decisions.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    div_cur_nxt_s  = div_cur_r;
    pend_nxt_s     = pend_r;
    pend_vld_nxt_s = pend_vld_r;
    pos_q_nxt_s    = pos_q_r;
    tick_nxt_s     = 1'b0;
    ack_nxt_s      = 1'b0;
    err_nxt_s      = load_bad_s;

    case (state_r)
      IDLE: begin
        cnt_nxt_s   = {CNT_W{1'b0}};
        pos_q_nxt_s = 1'b0;
        // Nothing is running, so a valid load can take effect at once.
        if (load_ok_s) begin
          div_cur_nxt_s  = div_i;
          pend_vld_nxt_s = 1'b0;
          ack_nxt_s      = 1'b1;
        end else begin
          div_cur_nxt_s  = div_cur_r;
        end
        if (en) begin
          state_nxt_s = RUN;
          pos_q_nxt_s = 1'b1;
          tick_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      RUN: begin
        // Mid-period loads are parked; the newest one wins.
        if (load_ok_s) begin
          pend_nxt_s     = div_i;
          pend_vld_nxt_s = 1'b1;
        end else begin
          pend_nxt_s     = pend_r;
        end
        if (wrap_s) begin
          cnt_nxt_s = {CNT_W{1'b0}};
          // A load arriving on the wrap edge itself is applied right here.
          if (load_ok_s || pend_vld_r) begin
            div_cur_nxt_s  = load_ok_s ? div_i : pend_r;
            pend_vld_nxt_s = 1'b0;
            ack_nxt_s      = 1'b1;
          end else begin
            div_cur_nxt_s  = div_cur_r;
          end
          if (en) begin
            pos_q_nxt_s = 1'b1;
            tick_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = IDLE;
            pos_q_nxt_s = 1'b0;
          end
        end else begin
          cnt_nxt_s   = cnt_inc_s;
          pos_q_nxt_s = (32'(cnt_inc_s) < hi_len(32'(div_cur_r)));
        end
      end

      default: begin
        state_nxt_s    = IDLE;
        cnt_nxt_s      = {CNT_W{1'b0}};
        pos_q_nxt_s    = 1'b0;
        pend_vld_nxt_s = 1'b0;
      end
    endcase
  end

  // Posedge state: FSM, period counter, divisor registers and output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      div_cur_r  <= DIV_RST_W;
      pend_r     <= {CNT_W{1'b0}};
      pend_vld_r <= 1'b0;
      pos_q_r    <= 1'b0;
      tick_r     <= 1'b0;
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      div_cur_r  <= div_cur_nxt_s;
      pend_r     <= pend_nxt_s;
      pend_vld_r <= pend_vld_nxt_s;
      pos_q_r    <= pos_q_nxt_s;
      tick_r     <= tick_nxt_s;
      ack_r      <= ack_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  generate
    if (ODD_50 != 0) begin : g_odd
      // Half-cycle-late copy of pos_q; ANDing trims the high phase by half a clk.
      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          neg_q_r <= 1'b0;
        end else begin
          neg_q_r <= pos_q_r;
        end
      end
    end else begin : g_even
      assign neg_q_r = 1'b0;
    end
  endgenerate

  assign odd_mode_s = (ODD_50 != 0) && div_cur_r[0];
  assign clk_out    = odd_mode_s ? (pos_q_r & neg_q_r) : pos_q_r;
  assign tick       = tick_r;
  assign div_cur    = div_cur_r;
  assign div_ack    = ack_r;
  assign div_err    = err_r;

  clk_div_stat #(
    .STAT_W (STAT_W)
  ) u_stat (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick_r),
    .clk_cnt (clk_cnt),
    .out_cnt (out_cnt)
  );

endmodule

// File: tb/tb_clk_div_n.sv
// Scoreboard bench for clk_div_n: per-cycle expected clk_out/tick/ack/err
// are queued with each stimulus step and compared as the DUT advances.
module tb_clk_div_n;

  localparam int HALF = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, en_odd;
  logic [7:0]  div_i;
  logic        div_load;

  logic        clk_out, tick, div_ack, div_err;
  logic [7:0]  div_cur;
  logic [31:0] clk_cnt, out_cnt;

  logic        o_clk_out, o_tick, o_div_ack, o_div_err;
  logic [7:0]  o_div_cur;
  logic [31:0] o_clk_cnt, o_out_cnt;

  int total_cnt = 0;
  int bad_cnt   = 0;

  typedef struct packed {
    logic co;
    logic tk;
    logic ack;
    logic err;
  } exp_t;

  exp_t sb_q[$];

  always #HALF clk = ~clk;

  clk_div_n #(.CNT_W(8), .DIV_DEFAULT(5), .ODD_50(0), .STAT_W(32)) u_dut (
    .clk(clk), .rst(rst), .en(en), .div_i(div_i), .div_load(div_load),
    .clk_out(clk_out), .tick(tick), .div_cur(div_cur), .div_ack(div_ack),
    .div_err(div_err), .clk_cnt(clk_cnt), .out_cnt(out_cnt)
  );

  clk_div_n #(.CNT_W(8), .DIV_DEFAULT(5), .ODD_50(1), .STAT_W(32)) u_odd (
    .clk(clk), .rst(rst), .en(en_odd), .div_i(8'd0), .div_load(1'b0),
    .clk_out(o_clk_out), .tick(o_tick), .div_cur(o_div_cur), .div_ack(o_div_ack),
    .div_err(o_div_err), .clk_cnt(o_clk_cnt), .out_cnt(o_out_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_e(input logic co, input logic tk, input logic ack, input logic err);
    exp_t e;
    e.co = co; e.tk = tk; e.ack = ack; e.err = err;
    sb_q.push_back(e);
  endtask

  // One full divided period of length n; ack marks the period a new divisor opens.
  task automatic push_period(input int n, input logic ack);
    for (int i = 0; i < n; i++) begin
      push_e((i < (n + 1) / 2), (i == 0), (ack && (i == 0)), 1'b0);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("clk_out", 64'(clk_out), 64'(e.co));
      check_val("tick",    64'(tick),    64'(e.tk));
      check_val("div_ack", 64'(div_ack), 64'(e.ack));
      check_val("div_err", 64'(div_err), 64'(e.err));
    end
  endtask

  task automatic drain();
    while (sb_q.size() > 0) step();
  endtask

  task automatic wait_lvl(input logic lvl, output longint t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 400; i++) begin
      if (o_clk_out === lvl) begin
        ok = 1'b1;
        t  = longint'($time);
        break;
      end
      #2;
    end
  endtask

  initial begin
    longint t0, t1, t2, tx;
    bit ok0, ok1, ok2, okx, oky;

    rst = 1'b1; en = 1'b0; en_odd = 1'b0; div_i = 8'd0; div_load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_clk_out", 64'(clk_out), 64'd0);
    check_val("rst_tick",    64'(tick),    64'd0);
    check_val("rst_div_cur", 64'(div_cur), 64'd5);
    check_val("rst_div_ack", 64'(div_ack), 64'd0);
    check_val("rst_div_err", 64'(div_err), 64'd0);
    check_val("rst_clk_cnt", 64'(clk_cnt), 64'd0);
    check_val("rst_out_cnt", 64'(out_cnt), 64'd0);

    // N=5 free run for 50 cycles: 1,1,1,0,0 pattern.
    rst = 1'b0; en = 1'b1; en_odd = 1'b1;
    for (int p = 0; p < 10; p++) push_period(5, 1'b0);
    drain();
    check_val("clk_cnt_50", 64'(clk_cnt), 64'd50);
    check_val("out_cnt_10", 64'(out_cnt), 64'd10);

    // Illegal divisor while running: error pulse, nothing else moves.
    push_period(5, 1'b0);
    sb_q[0].err = 1'b1;
    div_i = 8'd1; div_load = 1'b1;
    step();
    div_load = 1'b0;
    check_val("err_div_cur", 64'(div_cur), 64'd5);
    drain();

    // Drop en at cnt=1: period completes, then stays idle.
    push_period(5, 1'b0);
    step(); step();
    en = 1'b0;
    drain();
    push_e(1'b0, 1'b0, 1'b0, 1'b0);
    push_e(1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Load 4 while idle: ack the next cycle, then run 2 high / 2 low.
    push_e(1'b0, 1'b0, 1'b1, 1'b0);
    div_i = 8'd4; div_load = 1'b1;
    step();
    div_load = 1'b0;
    check_val("idle_div_cur", 64'(div_cur), 64'd4);
    en = 1'b1;
    push_period(4, 1'b0);
    push_period(4, 1'b0);
    repeat (5) step();
    en = 1'b0;
    drain();
    push_e(1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Back to N=5, then two loads in one running period; the last one wins.
    push_e(1'b0, 1'b0, 1'b1, 1'b0);
    div_i = 8'd5; div_load = 1'b1;
    step();
    div_load = 1'b0;
    en = 1'b1;
    push_period(5, 1'b0);
    push_period(6, 1'b1);
    push_period(6, 1'b0);
    step(); step(); step();
    div_i = 8'd8; div_load = 1'b1;
    step();
    div_i = 8'd6;
    step();
    div_load = 1'b0;
    check_val("pend_div_cur", 64'(div_cur), 64'd5);
    drain();
    check_val("new_div_cur", 64'(div_cur), 64'd6);

    // Async reset in the middle of a high phase.
    push_e(1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    rst = 1'b1;
    #1;
    check_val("mid_rst_clk_out", 64'(clk_out), 64'd0);
    check_val("mid_rst_tick",    64'(tick),    64'd0);
    check_val("mid_rst_div_cur", 64'(div_cur), 64'd5);
    check_val("mid_rst_clk_cnt", 64'(clk_cnt), 64'd0);
    check_val("mid_rst_out_cnt", 64'(out_cnt), 64'd0);
    check_val("mid_rst_odd_out", 64'(o_clk_out), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Odd-50 instance, N=5: 2.5 clk periods high, 2.5 low.
    wait_lvl(1'b1, tx, okx);
    wait_lvl(1'b0, tx, oky);
    wait_lvl(1'b1, t0, ok0);
    wait_lvl(1'b0, t1, ok1);
    wait_lvl(1'b1, t2, ok2);
    check_val("odd_edges_seen", 64'(okx & oky & ok0 & ok1 & ok2), 64'd1);
    check_val("odd_hi_time", 64'(t1 - t0), 64'(5 * HALF));
    check_val("odd_lo_time", 64'(t2 - t1), 64'(5 * HALF));

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
